// File: rtl/spec_branch_history.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spec_branch_history: speculative global history with checkpoints   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spec_branch_history #(
  parameter int HIST_W     = 8,
  parameter int CKPT_DEPTH = 4,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [TAG_W-1:0]  pred_tag,
  input  logic              res_valid,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic              res_taken,
  input  logic              res_mispredict,
  input  logic              flush,
  output logic [HIST_W-1:0] spec_hist,
  output logic [HIST_W-1:0] arch_hist,
  output logic [TAG_W:0]    occupancy,
  output logic              retire_valid,
  output logic              retire_taken
);

  localparam logic [TAG_W:0] C_FULL = (TAG_W+1)'(CKPT_DEPTH);

  logic [CKPT_DEPTH-1:0] r_valid;
  logic [CKPT_DEPTH-1:0] r_resolved;
  logic [CKPT_DEPTH-1:0] r_outcome;
  logic [HIST_W-1:0]     r_ckpt [CKPT_DEPTH];
  logic [TAG_W-1:0]      r_head;
  logic [TAG_W-1:0]      r_tail;
  logic [TAG_W:0]        r_occ;
  logic [HIST_W-1:0]     r_spec;
  logic [HIST_W-1:0]     r_arch;
  logic                  r_retire_valid;
  logic                  r_retire_taken;

  logic                  w_accept;
  logic                  w_res_hit;
  logic                  w_mispredict;
  logic                  w_correct;
  logic                  w_retire;
  logic [TAG_W-1:0]      w_age_t;
  logic [CKPT_DEPTH-1:0] w_valid_next;
  logic [CKPT_DEPTH-1:0] w_resolved_next;
  logic [CKPT_DEPTH-1:0] w_outcome_next;
  logic [TAG_W:0]        w_occ_next;

  assign pred_ready   = (r_occ != C_FULL) && !flush && !(res_valid && res_mispredict);
  assign pred_tag     = r_tail;
  assign w_accept     = pred_valid && pred_ready;
  assign w_res_hit    = res_valid && r_valid[res_tag] && !r_resolved[res_tag];
  assign w_mispredict = w_res_hit && res_mispredict && !flush;
  assign w_correct    = w_res_hit && !res_mispredict && !flush;
  assign w_retire     = r_valid[r_head] && r_resolved[r_head] && !flush;
  // Age relative to head orders entries even after the pointers wrap.
  assign w_age_t      = res_tag - r_head;

  always_comb begin
    w_valid_next    = r_valid;
    w_resolved_next = r_resolved;
    w_outcome_next  = r_outcome;
    if (flush) begin
      w_valid_next = '0;
    end else begin
      if (w_retire) w_valid_next[r_head] = 1'b0;
      if (w_mispredict || w_correct) begin
        w_resolved_next[res_tag] = 1'b1;
        w_outcome_next[res_tag]  = res_taken;
      end
      if (w_mispredict) begin
        for (int i = 0; i < CKPT_DEPTH; i++) begin
          if ((TAG_W'(i) - r_head) > w_age_t) w_valid_next[i] = 1'b0;
        end
      end
      if (w_accept) begin
        w_valid_next[r_tail]    = 1'b1;
        w_resolved_next[r_tail] = 1'b0;
      end
    end
  end

  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      w_occ_next = w_occ_next + (TAG_W+1)'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= '0;
      r_resolved     <= '0;
      r_outcome      <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) r_ckpt[i] <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_occ          <= '0;
      r_spec         <= '0;
      r_arch         <= '0;
      r_retire_valid <= 1'b0;
      r_retire_taken <= 1'b0;
    end else begin
      r_valid    <= w_valid_next;
      r_resolved <= w_resolved_next;
      r_outcome  <= w_outcome_next;
      r_occ      <= w_occ_next;
      if (w_accept) r_ckpt[r_tail] <= r_spec;
      if (flush) begin
        r_tail         <= r_head;
        r_spec         <= r_arch;
        r_retire_valid <= 1'b0;
        r_retire_taken <= 1'b0;
      end else begin
        r_retire_valid <= w_retire;
        r_retire_taken <= w_retire && r_outcome[r_head];
        if (w_retire) begin
          r_arch <= {r_arch[HIST_W-2:0], r_outcome[r_head]};
          r_head <= r_head + 1'b1;
        end
        if (w_mispredict) begin
          r_spec <= {r_ckpt[res_tag][HIST_W-2:0], res_taken};
          r_tail <= res_tag + 1'b1;
        end else if (w_accept) begin
          r_spec <= {r_spec[HIST_W-2:0], pred_taken};
          r_tail <= r_tail + 1'b1;
        end
      end
    end
  end

  assign spec_hist    = r_spec;
  assign arch_hist    = r_arch;
  assign occupancy    = r_occ;
  assign retire_valid = r_retire_valid;
  assign retire_taken = r_retire_taken;

endmodule
`default_nettype wire

// File: doc/spec_branch_history.md
Name: spec_branch_history

Overview:
Parametrised speculative global branch history register with per-branch checkpointing and out-of-order resolution. Fetch shifts predicted outcomes into a speculative history and receives a tag for each in-flight branch. Execute resolves branches by tag in any order; a mispredict restores history from that branch's checkpoint and squashes younger branches. Resolved branches retire in order into an architectural history. Sits between fetch-stage predictor indexing and the branch resolution unit.

Parameters:
HIST_W, 8, history length in bits (>=2)
CKPT_DEPTH, 4, max in-flight branches; power of two, >=2
TAG_W, $clog2(CKPT_DEPTH), tag width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
pred_valid  in  1  fetch presents predicted branch
pred_taken  in  1  predicted direction (1 = taken)
pred_ready  out  1  branch accepted this cycle when pred_valid && pred_ready
pred_tag  out  TAG_W  tag assigned to an accepted branch (= tail pointer)
res_valid  in  1  resolution strobe
res_tag  in  TAG_W  branch being resolved
res_taken  in  1  actual direction
res_mispredict  in  1  actual != predicted
flush  in  1  external pipeline flush
spec_hist  out  HIST_W  speculative history (registered)
arch_hist  out  HIST_W  retired history (registered)
occupancy  out  TAG_W+1  in-flight entries
retire_valid  out  1  one branch retired this cycle
retire_taken  out  1  direction of retired branch

Behaviour:
- Reset (reset_n low, async): spec_hist=0, arch_hist=0, occupancy=0, head=tail=0, all entry valid/resolved bits 0, retire_valid=0, retire_taken=0. Reset mid-operation discards all in-flight entries.
- Entry state per slot: valid, resolved, outcome, ckpt[HIST_W] (spec_hist before the branch's own shift).
- pred_ready = (occupancy != CKPT_DEPTH) && !flush && !(res_valid && res_mispredict). Combinational; ignores same-cycle frees.
- Accept: ckpt[tail]<=spec_hist, valid=1, resolved=0; spec_hist<={spec_hist[HIST_W-2:0], pred_taken}; tail++ (mod CKPT_DEPTH). pred_tag = tail, valid in the accept cycle.
- Correct resolve (res_valid, !res_mispredict, entry valid and unresolved): resolved<=1, outcome<=res_taken. spec_hist unaffected.
- Mispredict resolve (entry valid and unresolved): spec_hist<={ckpt[t][HIST_W-2:0], res_taken}; entry t resolved, outcome=res_taken; all entries younger than t invalidated; tail<=t+1.
- Resolve to an invalid or already-resolved tag: ignored, no state change.
- Retire: if head valid && resolved (registered state), one per cycle: arch_hist<={arch_hist[HIST_W-2:0], outcome}, entry invalidated, head++, retire_valid=1 and retire_taken=outcome for that cycle (registered, 1-cycle latency from resolved state). A resolve of the head tag retires no earlier than the next cycle.
- flush: all entries invalidated, tail<=head, spec_hist<=arch_hist; retire suppressed that cycle; resolve and predict ignored.
- Priority: reset > flush > mispredict > correct resolve/predict. Retire runs concurrently with predict, resolve and mispredict.
- occupancy = count of valid entries; updated in the same cycle as push/retire/squash; simultaneous push+retire leaves it unchanged.
- Pointers wrap modulo CKPT_DEPTH; full/empty come from occupancy, not pointer equality.

Test Plan:
- Reset mid-op: 3 branches in flight, spec_hist=0x05, assert reset_n low -> immediately spec_hist=0, arch_hist=0, occupancy=0, pred_ready=1.
- Fill: from reset, predict T,T,N,T -> tags 0,1,2,3; spec_hist=0x0D; occupancy=4; pred_ready=0; 5th pred_valid ignored, spec_hist stays 0x0D.
- Out-of-order correct resolve: resolve tag1 T, then tag0 T -> tag0 retires the cycle after its resolve, tag1 the following cycle; arch_hist=0x03; occupancy=2; retire_taken=1 both.
- Mispredict with younger branch: resolve tag2 mispredict actual T (ckpt2=0x03) while tag3 is in flight -> spec_hist=0x07, tag3 squashed, occupancy=1; next cycle tag2 retires, arch_hist=0x07, occupancy=0; next accepted pred_tag=3, the following one 0 (wrap).
- Collision: pred_valid with res_valid+res_mispredict in the same cycle -> pred_ready=0, predict dropped, spec_hist equals restored value only.
- Flush: arch_hist=0x07, two unresolved branches, spec_hist=0x1F -> after flush spec_hist=0x07, occupancy=0, retire_valid=0 that cycle.
